// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, T-state encoding, IR field positions and opcode-class helpers
// for the hardwired control sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int IR_OPC_HI = 31;
  localparam int IR_OPC_LO = 27;
  localparam int IR_RA_HI  = 26;
  localparam int IR_RA_LO  = 23;
  localparam int IR_RB_HI  = 22;
  localparam int IR_RB_LO  = 19;
  localparam int IR_RC_HI  = 18;
  localparam int IR_RC_LO  = 15;

  typedef enum logic [3:0] {
    S_T0        = 4'd0,
    S_T1        = 4'd1,
    S_T2        = 4'd2,
    S_T3        = 4'd3,
    S_T4        = 4'd4,
    S_T5        = 4'd5,
    S_T6        = 4'd6,
    S_HALTED    = 4'd7,
    S_STEP_WAIT = 4'd8
  } state_t;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic mdr_out;
    logic hi_out;
    logic lo_out;
    logic mar_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic y_in;
    logic zlo_in;
    logic zhi_in;
    logic hi_in;
    logic lo_in;
    logic read;
    logic inc_pc;
  } strobe_t;

  function automatic logic is_rtype(input logic [4:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL, OP_NEG, OP_NOT: is_rtype = 1'b1;
      default:                                 is_rtype = 1'b0;
    endcase
  endfunction

  function automatic logic is_unary(input logic [4:0] opc);
    case (opc)
      OP_NEG, OP_NOT: is_unary = 1'b1;
      default:        is_unary = 1'b0;
    endcase
  endfunction

  function automatic logic is_muldiv(input logic [4:0] opc);
    case (opc)
      OP_MUL, OP_DIV: is_muldiv = 1'b1;
      default:        is_muldiv = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_unit_reg_sel_decoder.sv
// Index-to-one-hot register select; indices at or beyond NREG give no select.
module reg_sel_decoder #(
  parameter int NREG = 16
) (
  input  logic [3:0]      idx,
  input  logic            en,
  output logic [NREG-1:0] sel
);

  // One-hot decode with out-of-range guard
  always_comb begin
    sel = '0;
    if (en && (int'(idx) < NREG)) begin
      sel[idx] = 1'b1;
    end else begin
      sel = '0;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Hardwired Moore T-state control sequencer for the single-bus datapath.
// Optional single-step mode is enabled by defining CU_SINGLE_STEP_EN.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int NREG        = 16,
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            clr,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     ir,
  input  logic            mem_rdy,
  input  logic            resume,
  output logic            PCout,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            ZLOin,
  output logic            ZHIin,
  output logic            HIin,
  output logic            LOin,
  output logic            Read,
  output logic            IncPC,
  output logic [OP_W-1:0] operation,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] enableReg,
  output logic            run,
  output logic            illegal_op,
  output logic            mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

`ifdef CU_SINGLE_STEP_EN
  localparam state_t END_STATE = S_STEP_WAIT;
`else
  localparam state_t END_STATE = S_T0;
`endif

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             mem_err_r;
  logic             timeout_s;

  logic [4:0]       opc_s;
  logic [3:0]       ra_s;
  logic [3:0]       rb_s;
  logic [3:0]       rc_s;
  logic             unused_ir_s;

  strobe_t          dec_strb_s;
  strobe_t          strb_s;
  logic [4:0]       dec_op_s;
  logic             dec_ill_s;
  logic [3:0]       rout_idx_s;
  logic             rout_en_s;
  logic [3:0]       wr_idx_s;
  logic             wr_en_s;

  assign opc_s       = ir[IR_OPC_HI:IR_OPC_LO];
  assign ra_s        = ir[IR_RA_HI:IR_RA_LO];
  assign rb_s        = ir[IR_RB_HI:IR_RB_LO];
  assign rc_s        = ir[IR_RC_HI:IR_RC_LO];
  assign unused_ir_s = ^ir[IR_RC_LO-1:0];

  // The last waiting T1 cycle with memory still silent is the fault point
  assign timeout_s = (state_r == S_T1) && !mem_rdy &&
                     (wait_cnt_r == CNT_W'(MEM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= S_T0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // T1 wait counter and sticky memory fault flag
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_cnt_r <= '0;
      mem_err_r  <= 1'b0;
    end else begin
      if ((state_r == S_T1) && !mem_rdy && !timeout_s) begin
        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = S_T0;
    case (state_r)
      S_T0: state_next_s = S_T1;
      S_T1: begin
        if (mem_rdy) begin
          state_next_s = S_T2;
        end else if (timeout_s) begin
          state_next_s = S_HALTED;
        end else begin
          state_next_s = S_T1;
        end
      end
      S_T2: state_next_s = S_T3;
      S_T3: begin
        if (is_rtype(opc_s) || is_muldiv(opc_s)) begin
          state_next_s = S_T4;
        end else if (opc_s == OP_HALT) begin
          state_next_s = S_HALTED;
        end else begin
          state_next_s = END_STATE;
        end
      end
      S_T4: state_next_s = S_T5;
      S_T5: begin
        if (is_muldiv(opc_s)) begin
          state_next_s = S_T6;
        end else begin
          state_next_s = END_STATE;
        end
      end
      S_T6: state_next_s = END_STATE;
      S_HALTED: begin
        if (resume) begin
          state_next_s = S_T0;
        end else begin
          state_next_s = S_HALTED;
        end
      end
`ifdef CU_SINGLE_STEP_EN
      S_STEP_WAIT: begin
        if (step) begin
          state_next_s = S_T0;
        end else begin
          state_next_s = S_STEP_WAIT;
        end
      end
`endif
      default: state_next_s = S_T0;
    endcase
  end

  // Moore output decode from state and instruction fields
  always_comb begin
    dec_strb_s = '0;
    dec_op_s   = 5'd0;
    dec_ill_s  = 1'b0;
    rout_idx_s = 4'd0;
    rout_en_s  = 1'b0;
    wr_idx_s   = 4'd0;
    wr_en_s    = 1'b0;
    case (state_r)
      S_T0: begin
        dec_strb_s.pc_out = 1'b1;
        dec_strb_s.mar_in = 1'b1;
        dec_strb_s.inc_pc = 1'b1;
        dec_strb_s.zlo_in = 1'b1;
      end
      S_T1: begin
        dec_strb_s.read   = 1'b1;
        dec_strb_s.mdr_in = 1'b1;
        // Only the first T1 cycle loads the incremented PC
        if (wait_cnt_r == '0) begin
          dec_strb_s.zlo_out = 1'b1;
          dec_strb_s.pc_in   = 1'b1;
        end else begin
          dec_strb_s.zlo_out = 1'b0;
          dec_strb_s.pc_in   = 1'b0;
        end
      end
      S_T2: begin
        dec_strb_s.mdr_out = 1'b1;
        dec_strb_s.ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_rtype(opc_s)) begin
          rout_idx_s      = rb_s;
          rout_en_s       = 1'b1;
          dec_strb_s.y_in = 1'b1;
        end else if (is_muldiv(opc_s)) begin
          rout_idx_s      = ra_s;
          rout_en_s       = 1'b1;
          dec_strb_s.y_in = 1'b1;
        end else if (opc_s == OP_MFHI) begin
          dec_strb_s.hi_out = 1'b1;
          wr_idx_s          = ra_s;
          wr_en_s           = 1'b1;
        end else if (opc_s == OP_MFLO) begin
          dec_strb_s.lo_out = 1'b1;
          wr_idx_s          = ra_s;
          wr_en_s           = 1'b1;
        end else if ((opc_s == OP_NOP) || (opc_s == OP_HALT)) begin
          dec_ill_s = 1'b0;
        end else begin
          dec_ill_s = 1'b1;
        end
      end
      S_T4: begin
        if (is_muldiv(opc_s)) begin
          rout_idx_s        = rb_s;
          rout_en_s         = 1'b1;
          dec_op_s          = opc_s;
          dec_strb_s.zlo_in = 1'b1;
          dec_strb_s.zhi_in = 1'b1;
        end else if (is_rtype(opc_s)) begin
          rout_idx_s        = is_unary(opc_s) ? rb_s : rc_s;
          rout_en_s         = 1'b1;
          dec_op_s          = opc_s;
          dec_strb_s.zlo_in = 1'b1;
        end else begin
          rout_en_s = 1'b0;
        end
      end
      S_T5: begin
        dec_strb_s.zlo_out = 1'b1;
        if (is_muldiv(opc_s)) begin
          dec_strb_s.lo_in = 1'b1;
        end else begin
          wr_idx_s = ra_s;
          wr_en_s  = 1'b1;
        end
      end
      S_T6: begin
        dec_strb_s.zhi_out = 1'b1;
        dec_strb_s.hi_in   = 1'b1;
      end
      default: dec_strb_s = '0;
    endcase
  end

  // Async reset must silence every strobe at once, even though the state reads T0
  always_comb begin
    strb_s = '0;
    if (clr) begin
      strb_s = dec_strb_s;
    end else begin
      strb_s = '0;
    end
  end

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .idx (rout_idx_s),
    .en  (rout_en_s && clr),
    .sel (Rout)
  );

  reg_sel_decoder #(.NREG(NREG)) u_wr_dec (
    .idx (wr_idx_s),
    .en  (wr_en_s && clr),
    .sel (enableReg)
  );

  assign PCout      = strb_s.pc_out;
  assign Zlowout    = strb_s.zlo_out;
  assign ZHighout   = strb_s.zhi_out;
  assign MDRout     = strb_s.mdr_out;
  assign HIout      = strb_s.hi_out;
  assign LOout      = strb_s.lo_out;
  assign MARin      = strb_s.mar_in;
  assign PCin       = strb_s.pc_in;
  assign MDRin      = strb_s.mdr_in;
  assign IRin       = strb_s.ir_in;
  assign Yin        = strb_s.y_in;
  assign ZLOin      = strb_s.zlo_in;
  assign ZHIin      = strb_s.zhi_in;
  assign HIin       = strb_s.hi_in;
  assign LOin       = strb_s.lo_in;
  assign Read       = strb_s.read;
  assign IncPC      = strb_s.inc_pc;
  assign operation  = clr ? OP_W'(dec_op_s) : '0;
  assign illegal_op = dec_ill_s && clr;
  assign run        = (state_r != S_HALTED);
  assign mem_err    = mem_err_r;

endmodule
